// File: rtl/led_pkg.sv
// Shared definitions for the LED ownership arbiter: requester indices,
// pattern codes, FSM state encoding and small decode helpers.
package led_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_HB  = 0;
  localparam int REQ_ISP = 1;
  localparam int REQ_ERR = 2;

  localparam logic [1:0] PAT_SOLID = 2'b00;
  localparam logic [1:0] PAT_SLOW  = 2'b01;
  localparam logic [1:0] PAT_FAST  = 2'b10;
  localparam logic [1:0] PAT_ALT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OWN  = 2'd2
  } state_e;

  // One-hot of the highest-priority asserted request, zero when none.
  function automatic logic [NUM_REQ-1:0] pick_highest(input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (r[REQ_ERR])      g[REQ_ERR] = 1'b1;
    else if (r[REQ_ISP]) g[REQ_ISP] = 1'b1;
    else if (r[REQ_HB])  g[REQ_HB]  = 1'b1;
    return g;
  endfunction

  // LED pair for a pattern code at the given phase; bit 0 is LED0.
  function automatic logic [1:0] led_decode(input logic [1:0] pat, input logic [2:0] phase);
    logic [1:0] led;
    case (pat)
      PAT_SOLID: led = 2'b11;
      PAT_SLOW:  led = {2{phase[2]}};
      PAT_FAST:  led = {2{phase[0]}};
      PAT_ALT:   led = {~phase[1], phase[1]};
      default:   led = 2'b00;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks,
// plus a 3-bit phase counter advanced on each tick.
module led_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [2:0] phase
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [2:0]    phase_q, phase_d;

  assign tick  = (cnt_q == LAST);
  assign phase = phase_q;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + PW'(1);
    phase_d = tick ? phase_q + 3'd1 : phase_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Priority arbiter granting the LED pair to one of three requesters with a
// minimum hold time, and driving the owner's blink pattern.
module led_arbiter
  import led_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int MIN_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_pat,
  output logic [NUM_REQ-1:0]     grant,
  output logic [1:0]             o_LED,
  output logic                   busy
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD);

  logic       tick;
  logic [2:0] phase;

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .phase (phase)
  );

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [HW-1:0]      hold_q;
  logic [1:0]         led_q;

  logic [NUM_REQ-1:0] top_req;
  logic [NUM_REQ-1:0] above_owner;
  logic               owner_req;
  logic               preempt;
  logic               release_own;
  logic [1:0]         owner_pat;
  logic [1:0]         led_d;

  always_comb begin
    top_req     = pick_highest(req);
    owner_req   = |(req & grant_q);
    // Requesters strictly above the current owner in priority.
    above_owner = {grant_q[REQ_ISP] | grant_q[REQ_HB], grant_q[REQ_HB], 1'b0};
    preempt     = (|(req & above_owner)) | (!owner_req && (|req));
    release_own = !(|req);
    owner_pat   = PAT_SOLID;
    if (grant_q[REQ_ERR])      owner_pat = req_pat[2*REQ_ERR +: 2];
    else if (grant_q[REQ_ISP]) owner_pat = req_pat[2*REQ_ISP +: 2];
    else if (grant_q[REQ_HB])  owner_pat = req_pat[2*REQ_HB +: 2];
    led_d       = (|grant_q) ? led_decode(owner_pat, phase) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      led_q   <= 2'b00;
    end else begin
      led_q <= led_d;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q <= top_req;
            hold_q  <= HOLD_LOAD;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Requests are ignored until the hold window expires.
          if (tick) begin
            if (hold_q == HW'(1)) begin
              hold_q  <= '0;
              state_q <= ST_OWN;
            end else begin
              hold_q <= hold_q - HW'(1);
            end
          end
        end
        ST_OWN: begin
          if (release_own) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else if (preempt) begin
            grant_q <= top_req;
            hold_q  <= HOLD_LOAD;
            state_q <= ST_HOLD;
          end
        end
        default: begin
          grant_q <= '0;
          hold_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign o_LED = led_q;
  assign busy  = |grant_q;

endmodule
